// File: rtl/io_port_arbiter_pkg.sv
// Shared definitions for the PicoBlaze-style I/O port bus arbiter.
// Contains the state encoding, requester limit and default bus widths.
package io_arb_pkg;

    localparam int unsigned NREQ_MAX = 4;
    localparam int unsigned AW_DEF   = 8;
    localparam int unsigned DW_DEF   = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR   = 3'd1;
    localparam logic [2:0] RD   = 3'd2;
    localparam logic [2:0] RDW  = 3'd3;
    localparam logic [2:0] ACK  = 3'd4;

endpackage

// File: rtl/io_port_arbiter_if.sv
// Requester handshake plus shared port bus of io_port_arbiter.
// With IO_ARB_LOCK_EN defined, a per-requester lock vector is added.
interface io_port_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 8,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic [AW-1:0]      port_id;
    logic [DW-1:0]      out_port;
    logic               write_strobe;
    logic               read_strobe;
    logic [DW-1:0]      in_port;
`ifdef IO_ARB_LOCK_EN
    logic [NREQ-1:0]    lock;

    modport slave (
        input  req, we, addr, wdata, in_port, lock,
        output ack, rdata, port_id, out_port, write_strobe, read_strobe
    );
    modport master (
        output req, we, addr, wdata, in_port, lock,
        input  ack, rdata, port_id, out_port, write_strobe, read_strobe
    );
`else
    modport slave (
        input  req, we, addr, wdata, in_port,
        output ack, rdata, port_id, out_port, write_strobe, read_strobe
    );
    modport master (
        output req, we, addr, wdata, in_port,
        input  ack, rdata, port_id, out_port, write_strobe, read_strobe
    );
`endif
endinterface

// File: rtl/io_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', with wrap.
// Indices at or above NREQ are never produced, so unused codes are skipped.
module rr_pick #(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   grant,
    output logic            valid
);
    logic [IW-1:0] idx;

    // Scan farthest-first so the nearest requester after 'last' is written last.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = |req;
        for (int k = int'(NREQ); k >= 1; k--) begin
            idx = IW'((int'(last) + k) % int'(NREQ));
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/io_port_arbiter.sv
// Round-robin arbiter sharing one PicoBlaze-style I/O port bus among NREQ requesters.
// Optional IO_ARB_LOCK_EN adds lock inputs for atomic back-to-back grants.
module io_port_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input logic              clk,
    input logic              rst,
    io_port_arbiter_if.slave bus
);
    localparam int unsigned IW = $clog2(NREQ);

    state_t          state, state_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [IW-1:0]   gnt, gnt_nxt;
    logic [IW-1:0]   pick, sel;
    logic            pick_vld, relock;
    logic [NREQ-1:0] ack_sel;

    logic [AW-1:0]   port_id_q, port_id_nxt;
    logic [DW-1:0]   out_port_q, out_port_nxt;
    logic [DW-1:0]   rdata_q, rdata_nxt;
    logic [NREQ-1:0] ack_q, ack_nxt;
    logic            ws_q, ws_nxt;
    logic            rs_q, rs_nxt;

    logic [AW-1:0]   addr_a  [NREQ];
    logic [DW-1:0]   wdata_a [NREQ];

    for (genvar i = 0; i < int'(NREQ); i++) begin : g_split
        assign addr_a[i]  = bus.addr[i*AW +: AW];
        assign wdata_a[i] = bus.wdata[i*DW +: DW];
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req),
        .last  (last),
        .grant (pick),
        .valid (pick_vld)
    );

`ifdef IO_ARB_LOCK_EN
    logic lock_hold, lock_hold_nxt;
    // A lock seen in ACK re-grants the same requester in the very next IDLE cycle.
    assign relock = lock_hold & bus.req[gnt];
`else
    assign relock = 1'b0;
`endif

    assign sel     = relock ? gnt : pick;
    assign ack_sel = NREQ'(1) << gnt;

    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        gnt_nxt      = gnt;
        port_id_nxt  = port_id_q;
        out_port_nxt = out_port_q;
        rdata_nxt    = rdata_q;
        ack_nxt      = '0;
        ws_nxt       = 1'b0;
        rs_nxt       = 1'b0;
`ifdef IO_ARB_LOCK_EN
        lock_hold_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (relock || pick_vld) begin
                    gnt_nxt      = sel;
                    port_id_nxt  = addr_a[sel];
                    out_port_nxt = wdata_a[sel];
                    if (!relock) begin
                        last_nxt = sel;
                    end
                    if (bus.we[sel]) begin
                        state_nxt = WR;
                        ws_nxt    = 1'b1;
                    end else begin
                        state_nxt = RD;
                        rs_nxt    = 1'b1;
                    end
                end
            end
            WR: begin
                state_nxt = ACK;
                ack_nxt   = ack_sel;
            end
            RD: begin
                state_nxt = RDW;
            end
            RDW: begin
                state_nxt = ACK;
                rdata_nxt = bus.in_port;
                ack_nxt   = ack_sel;
            end
            ACK: begin
                state_nxt = IDLE;
`ifdef IO_ARB_LOCK_EN
                lock_hold_nxt = bus.lock[gnt];
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= IW'(NREQ - 1);
            gnt        <= '0;
            port_id_q  <= '0;
            out_port_q <= '0;
            rdata_q    <= '0;
            ack_q      <= '0;
            ws_q       <= 1'b0;
            rs_q       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            gnt        <= gnt_nxt;
            port_id_q  <= port_id_nxt;
            out_port_q <= out_port_nxt;
            rdata_q    <= rdata_nxt;
            ack_q      <= ack_nxt;
            ws_q       <= ws_nxt;
            rs_q       <= rs_nxt;
        end
    end

`ifdef IO_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_hold <= 1'b0;
        end else begin
            lock_hold <= lock_hold_nxt;
        end
    end
`endif

    assign bus.port_id      = port_id_q;
    assign bus.out_port     = out_port_q;
    assign bus.rdata        = rdata_q;
    assign bus.ack          = ack_q;
    assign bus.write_strobe = ws_q;
    assign bus.read_strobe  = rs_q;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Self-checking bench for io_port_arbiter: directed cases plus random traffic
// compared against a cycle-timeline reference model of the arbitration rules.
module tb_io_port_arbiter;
    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 8;
    localparam int MAXC = 4096;
    localparam int M_DIR = 0, M_RAND = 1, M_HOLD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
    io_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Attached port devices: registered input mux and level-sensitive output ports.
    logic [DW-1:0] in_mem  [256];
    logic [DW-1:0] out_mem [256] = '{default: '0};
    logic [DW-1:0] exp_mem [256];
    always @(posedge clk) bus.in_port <= in_mem[bus.port_id];
    always @(posedge clk) if (bus.write_strobe) out_mem[bus.port_id] <= bus.out_port;

    // Expected output timeline, one entry per cycle.
    logic [NREQ-1:0] e_ack [MAXC];
    logic            e_ws  [MAXC];
    logic            e_rs  [MAXC];
    logic [AW-1:0]   e_pid [MAXC];
    logic [DW-1:0]   e_out [MAXC];
    logic [DW-1:0]   e_rd  [MAXC];

    int n_chk = 0, n_fail = 0;
    int cyc = -1;
    int mode = M_DIR;
    int rst_at = -1;
    int lock_left = 0;

    bit            busy [NREQ], pend [NREQ], drop [NREQ];
    logic          p_we [NREQ];
    logic [AW-1:0] p_addr [NREQ];
    logic [DW-1:0] p_wd [NREQ];
    int            raise_cyc [NREQ];

    int m_free = 0, m_last = NREQ - 1, m_g = 0, m_ack_cyc = -1;
    bit m_lock = 0;

    int last_ack_cyc = -1;
    logic [NREQ-1:0] last_ack = '0;
    logic [NREQ-1:0] seq_exp [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        chk("ack",          32'(bus.ack),          32'(e_ack[cyc]));
        chk("write_strobe", 32'(bus.write_strobe), 32'(e_ws[cyc]));
        chk("read_strobe",  32'(bus.read_strobe),  32'(e_rs[cyc]));
        chk("port_id",      32'(bus.port_id),      32'(e_pid[cyc]));
        chk("out_port",     32'(bus.out_port),     32'(e_out[cyc]));
        chk("rdata",        32'(bus.rdata),        32'(e_rd[cyc]));
        chk("strobe_excl",  32'(bus.write_strobe & bus.read_strobe), 32'd0);
        chk("ack_onehot",   32'($countones(bus.ack) <= 1), 32'd1);
        if (bus.ack != '0) begin
            last_ack_cyc = cyc;
            last_ack     = bus.ack;
            if (seq_exp.size() > 0) chk("grant_seq", 32'(bus.ack), 32'(seq_exp.pop_front()));
        end
    endtask

    task automatic new_vals(input int i);
        p_we[i]   = 1'($urandom_range(0, 1));
        p_addr[i] = AW'($urandom_range(0, 15));
        p_wd[i]   = DW'($urandom);
    endtask

    task automatic drive();
        bit dropped;
        rst = (cyc == rst_at);
        for (int i = 0; i < NREQ; i++) begin
            dropped = 0;
            if (drop[i]) begin
                drop[i] = 0;
                busy[i] = 0;
                if (mode == M_HOLD) begin
                    new_vals(i);
                    pend[i] = 1;
                end else begin
                    bus.req[i] = 1'b0;
                    dropped = 1;
                end
            end
            if (e_ack[cyc][i]) drop[i] = 1;
            if (mode == M_RAND && !dropped && !busy[i] && !pend[i] && $urandom_range(0, 3) == 0) begin
                new_vals(i);
                pend[i] = 1;
            end
            if (pend[i]) begin
                pend[i] = 0;
                busy[i] = 1;
                bus.req[i] = 1'b1;
                bus.we[i]  = p_we[i];
                bus.addr[i*AW +: AW]  = p_addr[i];
                bus.wdata[i*DW +: DW] = p_wd[i];
                raise_cyc[i] = cyc;
            end
        end
`ifdef IO_ARB_LOCK_EN
        bus.lock = '0;
        bus.lock[0] = (lock_left > 0);
        if (e_ack[cyc][0] && lock_left > 0) lock_left--;
`endif
        if (rst) begin
            bus.req = '0;
            for (int i = 0; i < NREQ; i++) begin
                busy[i] = 0; pend[i] = 0; drop[i] = 0;
            end
        end
    endtask

    // Timeline model: a grant in cycle c fixes every output from c+1 onward.
    task automatic model_eval();
        int g;
        bit found;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (rst) begin
            for (int k = cyc + 1; k < MAXC; k++) begin
                e_ack[k] = '0; e_ws[k] = 0; e_rs[k] = 0;
                e_pid[k] = '0; e_out[k] = '0; e_rd[k] = '0;
            end
            m_free = cyc + 1; m_last = NREQ - 1; m_lock = 0; m_ack_cyc = -1;
            return;
        end
`ifdef IO_ARB_LOCK_EN
        if (cyc == m_ack_cyc) m_lock = bus.lock[m_g];
`endif
        if (cyc < m_free || bus.req == '0) return;
        found = 0;
        g = 0;
        if (m_lock && cyc == m_free && bus.req[m_g]) begin
            g = m_g;
            found = 1;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && bus.req[(m_last + k) % NREQ]) begin
                    g = (m_last + k) % NREQ;
                    found = 1;
                end
            end
            m_last = g;
        end
        m_lock = 0;
        m_g = g;
        a = bus.addr[g*AW +: AW];
        d = bus.wdata[g*DW +: DW];
        for (int k = cyc + 1; k < MAXC; k++) begin
            e_pid[k] = a;
            e_out[k] = d;
        end
        if (bus.we[g]) begin
            e_ws[cyc+1]  = 1;
            e_ack[cyc+2] = NREQ'(1) << g;
            m_ack_cyc = cyc + 2;
            m_free    = cyc + 3;
            exp_mem[a] = d;
        end else begin
            e_rs[cyc+1]  = 1;
            e_ack[cyc+3] = NREQ'(1) << g;
            for (int k = cyc + 3; k < MAXC; k++) e_rd[k] = in_mem[a];
            m_ack_cyc = cyc + 3;
            m_free    = cyc + 4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
        drive();
        model_eval();
    endtask

    function automatic bit quiet();
        bit q = (cyc >= m_free);
        for (int i = 0; i < NREQ; i++) if (busy[i] || pend[i] || drop[i]) q = 0;
        return q;
    endfunction

    task automatic run_until_quiet(input string tag, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!quiet() && n < budget);
        chk(tag, 32'(quiet()), 32'd1);
    endtask

    task automatic run_seq(input string tag, input int budget);
        int n = 0;
        while (seq_exp.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(seq_exp.size()), 32'd0);
        seq_exp.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
`ifdef IO_ARB_LOCK_EN
        bus.lock = '0;
`endif
        for (int a = 0; a < 256; a++) begin
            in_mem[a]  = DW'($urandom);
            exp_mem[a] = '0;
        end
        in_mem[2] = 8'h3C;
        for (int k = 0; k < MAXC; k++) begin
            e_ack[k] = '0; e_ws[k] = 0; e_rs[k] = 0;
            e_pid[k] = '0; e_out[k] = '0; e_rd[k] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            busy[i] = 0; pend[i] = 0; drop[i] = 0; raise_cyc[i] = 0;
        end
        repeat (2) @(posedge clk);

        // Single write from requester 0.
        mode = M_DIR;
        p_we[0] = 1'b1; p_addr[0] = 8'h05; p_wd[0] = 8'hA5; pend[0] = 1;
        run_until_quiet("wr_done", 20);
        chk("wr_latency", 32'(last_ack_cyc - raise_cyc[0]), 32'd2);
        chk("wr_ack_id", 32'(last_ack), 32'd1);
        chk("outport_05", 32'(out_mem[8'h05]), 32'hA5);

        // Single read from requester 1.
        p_we[1] = 1'b0; p_addr[1] = 8'h02; p_wd[1] = 8'h00; pend[1] = 1;
        run_until_quiet("rd_done", 20);
        chk("rd_latency", 32'(last_ack_cyc - raise_cyc[1]), 32'd3);
        chk("rd_ack_id", 32'(last_ack), 32'd2);
        chk("rd_data", 32'(bus.rdata), 32'h3C);

        // Contention from reset: both requesters hold req continuously.
        rst_at = cyc + 1;
        step();
        mode = M_HOLD;
        for (int i = 0; i < NREQ; i++) begin new_vals(i); pend[i] = 1; end
        seq_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        run_seq("hold_seq", 40);
        mode = M_DIR;
        run_until_quiet("hold_done", 20);

        // Reset landing in the read-wait cycle, then both request.
        p_we[1] = 1'b0; p_addr[1] = 8'h07; pend[1] = 1;
        rst_at = cyc + 3;
        repeat (4) step();
        chk("rst_rdw_quiet", 32'(quiet()), 32'd1);
        for (int i = 0; i < NREQ; i++) begin new_vals(i); pend[i] = 1; end
        seq_exp = '{2'b01, 2'b10};
        run_seq("post_rst_seq", 20);
        run_until_quiet("post_rst_done", 20);

`ifdef IO_ARB_LOCK_EN
        // Lock held by requester 0 for its first two acks.
        rst_at = cyc + 1;
        step();
        mode = M_HOLD;
        lock_left = 2;
        for (int i = 0; i < NREQ; i++) begin new_vals(i); pend[i] = 1; end
        seq_exp = '{2'b01, 2'b01, 2'b01, 2'b10};
        run_seq("lock_seq", 40);
        mode = M_DIR;
        run_until_quiet("lock_done", 20);
`endif

        // Random traffic.
        mode = M_RAND;
        repeat (2500) step();
        mode = M_DIR;
        run_until_quiet("rand_done", 40);

        for (int a = 0; a < 16; a++) chk("out_mem", 32'(out_mem[a]), 32'(exp_mem[a]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
